// File: rtl/button_conditioner_if.sv
// Button conditioner bundle: raw active-low keys in, conditioned step/dir controls out.
//   key_step_n, key_dir_n : raw asynchronous push-buttons (0 = pressed)
//   step_pulse            : one-cycle step strobe (press and auto-repeat)
//   dir                   : direction level, toggles per debounced dir press
//   step_held, dir_held   : debounced button levels (1 = pressed)
// master = board/chaser side, slave = the conditioner itself.
interface button_conditioner_if;
    logic key_step_n;
    logic key_dir_n;
    logic step_pulse;
    logic dir;
    logic step_held;
    logic dir_held;

    modport master (
        output key_step_n,
        output key_dir_n,
        input  step_pulse,
        input  dir,
        input  step_held,
        input  dir_held
    );

    modport slave (
        input  key_step_n,
        input  key_dir_n,
        output step_pulse,
        output dir,
        output step_held,
        output dir_held
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces the step and direction push-buttons for the LED chaser.
//   CLOCK_50 : system clock, all logic on rising edge
//   reset    : synchronous, active-high reset
//   btn      : slave side of button_conditioner_if (raw keys in, step/dir controls out)
// All outputs come straight from flops; there is no combinational input-to-output path.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    button_conditioner_if.slave  btn
);

    localparam int unsigned NCH     = 2;
    localparam int unsigned CH_STEP = 0;
    localparam int unsigned CH_DIR  = 1;

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic             REPEAT_EN   = (REPEAT_DELAY != 0);

    typedef enum logic {
        PH_INITIAL = 1'b0,
        PH_REPEAT  = 1'b1
    } phase_t;

    // Synchroniser flops keep the raw active-low polarity; debounced state is active-high.
    logic [NCH-1:0]   sync1_q;
    logic [NCH-1:0]   sync2_q;
    logic [NCH-1:0]   held_q, held_d;
    logic [CNT_W-1:0] db_cnt_q [NCH];
    logic [CNT_W-1:0] db_cnt_d [NCH];

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             pulse_q, pulse_d;
    logic             dir_q, dir_d;

    logic             step_rise;
    logic             step_stay;
    logic             dir_rise;
    logic [CNT_W-1:0] rep_last;

    // State register: synchronisers, debouncers, repeat engine, outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            held_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                db_cnt_q[i] <= '0;
            end
            phase_q <= PH_INITIAL;
            rcnt_q  <= '0;
            pulse_q <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            sync1_q <= {btn.key_dir_n, btn.key_step_n};
            sync2_q <= sync1_q;
            held_q  <= held_d;
            for (int i = 0; i < NCH; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            phase_q <= phase_d;
            rcnt_q  <= rcnt_d;
            pulse_q <= pulse_d;
            dir_q   <= dir_d;
        end
    end

    // Next-state logic.
    always_comb begin
        held_d  = held_q;
        phase_d = phase_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        dir_d   = dir_q;
        for (int i = 0; i < NCH; i++) begin
            db_cnt_d[i] = '0;
        end

        // Debounce: count consecutive disagreements; any agreement restarts the count.
        for (int i = 0; i < NCH; i++) begin
            if (~sync2_q[i] != held_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    held_d[i] = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            end
        end

        step_rise = held_d[CH_STEP] & ~held_q[CH_STEP];
        step_stay = held_d[CH_STEP] &  held_q[CH_STEP];
        dir_rise  = held_d[CH_DIR]  & ~held_q[CH_DIR];
        rep_last  = (phase_q == PH_INITIAL) ? DELAY_LAST : PERIOD_LAST;

        // Step pulse on press, then auto-repeat while held; a release on this edge
        // takes the else branch, so a coincident repeat pulse is dropped.
        if (step_rise) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
            phase_d = PH_INITIAL;
        end else if (step_stay && REPEAT_EN) begin
            if (rcnt_q == rep_last) begin
                pulse_d = 1'b1;
                rcnt_d  = '0;
                phase_d = PH_REPEAT;
            end else begin
                rcnt_d = rcnt_q + CNT_W'(1);
            end
        end else begin
            rcnt_d  = '0;
            phase_d = PH_INITIAL;
        end

        // Direction flips together with the debounced press, so both update in one cycle.
        if (dir_rise) begin
            dir_d = ~dir_q;
        end
    end

    assign btn.step_pulse = pulse_q;
    assign btn.dir        = dir_q;
    assign btn.step_held  = held_q[CH_STEP];
    assign btn.dir_held   = held_q[CH_DIR];

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=3, plus a second instance with REPEAT_DELAY=0).
// Expected step_pulse cycles are queued as stimulus is driven; a monitor pops and
// compares them whenever the DUT pulses. Cycle numbers count rising edges.
module tb_button_conditioner;

    logic CLOCK_50 = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_q[$];

    button_conditioner_if bi();
    button_conditioner_if if0();

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .CNT_W(8)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .btn(bi.slave)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3), .CNT_W(8)
    ) dut0 (
        .CLOCK_50(CLOCK_50), .reset(reset), .btn(if0.slave)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc++;

    // Scoreboard: every observed pulse must match the next queued expected cycle.
    always @(negedge CLOCK_50) begin
        int e;
        if (bi.step_pulse === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pulse_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e) begin
                    failures++;
                    $display("FAIL pulse_cycle: pulse at cycle %0d, expected %0d", cyc, e);
                end
            end
        end
    end

    // Advance to the falling edge after rising edge n.
    task automatic goto(input int n);
        while (cyc < n) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        int r;
        reset = 1'b1;
        bi.key_step_n = 1'b0;
        bi.key_dir_n  = 1'b0;
        if0.key_step_n = 1'b1;
        if0.key_dir_n  = 1'b1;
        goto(3);
        checks++;
        if ({bi.step_pulse, bi.dir, bi.step_held, bi.dir_held} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {bi.step_pulse, bi.dir, bi.step_held, bi.dir_held});
        end
        r = cyc;
        reset = 1'b0;
        exp_q.push_back(r + 6);
        goto(r + 5);
        checks++;
        if ({bi.step_held, bi.dir_held} !== 2'b00) begin
            failures++;
            $display("FAIL reset_held_early: got %b expected 00", {bi.step_held, bi.dir_held});
        end
        goto(r + 6);
        checks++;
        if ({bi.step_held, bi.dir_held, bi.dir} !== 3'b111) begin
            failures++;
            $display("FAIL reset_held_rise: got %b expected 111",
                     {bi.step_held, bi.dir_held, bi.dir});
        end
        bi.key_step_n = 1'b1;
        goto(r + 8);
        bi.key_dir_n = 1'b1;
        goto(r + 20);
        checks++;
        if ({bi.step_held, bi.dir_held, bi.dir, exp_q.size() == 0} !== 4'b0011) begin
            failures++;
            $display("FAIL reset_idle: got held/dir/qempty=%b expected 0011",
                     {bi.step_held, bi.dir_held, bi.dir, exp_q.size() == 0});
        end
    endtask

    task automatic test_press_release();
        int t0 = cyc;
        goto(t0 + 9);
        bi.key_step_n = 1'b0;
        exp_q.push_back(t0 + 15);
        goto(t0 + 14);
        checks++;
        if (bi.step_held !== 1'b0) begin
            failures++;
            $display("FAIL press_held_early: got %b expected 0", bi.step_held);
        end
        goto(t0 + 15);
        checks++;
        if (bi.step_held !== 1'b1) begin
            failures++;
            $display("FAIL press_held: got %b expected 1", bi.step_held);
        end
        goto(t0 + 16);
        bi.key_step_n = 1'b1;
        goto(t0 + 21);
        checks++;
        if (bi.step_held !== 1'b1) begin
            failures++;
            $display("FAIL release_held_early: got %b expected 1", bi.step_held);
        end
        goto(t0 + 22);
        checks++;
        if (bi.step_held !== 1'b0) begin
            failures++;
            $display("FAIL release_held: got %b expected 0", bi.step_held);
        end
        goto(t0 + 35);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL press_missing_pulse: %0d pulses outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_bounce();
        int t0 = cyc;
        goto(t0 + 15);
        bi.key_step_n = 1'b0;
        goto(t0 + 18);
        bi.key_step_n = 1'b1;
        goto(t0 + 19);
        bi.key_step_n = 1'b0;
        exp_q.push_back(t0 + 25);
        goto(t0 + 22);
        checks++;
        if (bi.step_held !== 1'b0) begin
            failures++;
            $display("FAIL bounce_held_glitch: got %b expected 0", bi.step_held);
        end
        goto(t0 + 24);
        checks++;
        if (bi.step_held !== 1'b0) begin
            failures++;
            $display("FAIL bounce_held_early: got %b expected 0", bi.step_held);
        end
        goto(t0 + 25);
        checks++;
        if (bi.step_held !== 1'b1) begin
            failures++;
            $display("FAIL bounce_held: got %b expected 1", bi.step_held);
        end
        goto(t0 + 26);
        bi.key_step_n = 1'b1;
        goto(t0 + 40);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL bounce_missing_pulse: %0d pulses outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_repeat();
        int t0 = cyc;
        int p;
        int npulse = 0;
        int first = -1;
        goto(t0 + 1);
        bi.key_step_n = 1'b0;
        p = t0 + 7;
        exp_q.push_back(p);
        exp_q.push_back(p + 8);
        for (int k = 11; k <= 23; k += 3) exp_q.push_back(p + k);
        goto(p + 19);
        bi.key_step_n = 1'b1;
        goto(p + 24);
        checks++;
        if (bi.step_held !== 1'b1) begin
            failures++;
            $display("FAIL repeat_held: got %b expected 1", bi.step_held);
        end
        goto(p + 40);
        checks++;
        if ({bi.step_held, exp_q.size() == 0} !== 2'b01) begin
            failures++;
            $display("FAIL repeat_end: held=%b outstanding=%0d, expected held=0 outstanding=0",
                     bi.step_held, exp_q.size());
        end

        // Auto-repeat disabled: exactly one pulse, at P.
        t0 = cyc;
        goto(t0 + 1);
        if0.key_step_n = 1'b0;
        for (int c = t0 + 2; c <= t0 + 40; c++) begin
            goto(c);
            if (if0.step_pulse === 1'b1) begin
                npulse++;
                if (first < 0) first = cyc;
            end
        end
        if0.key_step_n = 1'b1;
        checks++;
        if (npulse !== 1 || first !== t0 + 7) begin
            failures++;
            $display("FAIL norepeat_pulses: count=%0d first=%0d, expected count=1 first=%0d",
                     npulse, first, t0 + 7);
        end
        goto(cyc + 10);
    endtask

    task automatic test_dir();
        int t0;
        reset = 1'b1;
        goto(cyc + 2);
        reset = 1'b0;
        t0 = cyc;
        checks++;
        if (bi.dir !== 1'b0) begin
            failures++;
            $display("FAIL dir_after_reset: got %b expected 0", bi.dir);
        end
        goto(t0 + 1);
        bi.key_dir_n = 1'b0;
        goto(t0 + 6);
        checks++;
        if ({bi.dir_held, bi.dir} !== 2'b00) begin
            failures++;
            $display("FAIL dir_pre1: got %b expected 00", {bi.dir_held, bi.dir});
        end
        goto(t0 + 7);
        checks++;
        if ({bi.dir_held, bi.dir} !== 2'b11) begin
            failures++;
            $display("FAIL dir_press1: got %b expected 11", {bi.dir_held, bi.dir});
        end
        goto(t0 + 11);
        bi.key_dir_n = 1'b1;
        goto(t0 + 21);
        checks++;
        if ({bi.dir_held, bi.dir} !== 2'b01) begin
            failures++;
            $display("FAIL dir_release1: got %b expected 01", {bi.dir_held, bi.dir});
        end
        bi.key_dir_n = 1'b0;
        goto(t0 + 26);
        checks++;
        if (bi.dir !== 1'b1) begin
            failures++;
            $display("FAIL dir_pre2: got %b expected 1", bi.dir);
        end
        goto(t0 + 27);
        checks++;
        if ({bi.dir_held, bi.dir} !== 2'b10) begin
            failures++;
            $display("FAIL dir_press2: got %b expected 10", {bi.dir_held, bi.dir});
        end
        goto(t0 + 31);
        bi.key_dir_n = 1'b1;

        // Both keys together: step pulse and dir toggle land in the same cycle.
        goto(t0 + 41);
        bi.key_dir_n  = 1'b0;
        bi.key_step_n = 1'b0;
        exp_q.push_back(t0 + 47);
        goto(t0 + 46);
        checks++;
        if (bi.dir !== 1'b0) begin
            failures++;
            $display("FAIL both_pre: dir got %b expected 0", bi.dir);
        end
        goto(t0 + 47);
        checks++;
        if ({bi.step_pulse, bi.dir} !== 2'b11) begin
            failures++;
            $display("FAIL both_same_cycle: pulse/dir got %b expected 11", {bi.step_pulse, bi.dir});
        end
        goto(t0 + 48);
        bi.key_dir_n  = 1'b1;
        bi.key_step_n = 1'b1;
        goto(t0 + 65);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL both_missing_pulse: %0d pulses outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_repeat();
        int t0 = cyc;
        int p;
        goto(t0 + 1);
        bi.key_step_n = 1'b0;
        p = t0 + 7;
        exp_q.push_back(p);
        exp_q.push_back(p + 8);
        exp_q.push_back(p + 15);
        goto(p + 8);
        reset = 1'b1;
        goto(p + 9);
        reset = 1'b0;
        checks++;
        if ({bi.step_pulse, bi.step_held, bi.dir} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_outputs: got %b expected 000",
                     {bi.step_pulse, bi.step_held, bi.dir});
        end
        goto(p + 14);
        checks++;
        if (bi.step_held !== 1'b0) begin
            failures++;
            $display("FAIL midreset_held_early: got %b expected 0", bi.step_held);
        end
        goto(p + 15);
        checks++;
        if ({bi.step_held, bi.dir} !== 2'b10) begin
            failures++;
            $display("FAIL midreset_repress: held/dir got %b expected 10", {bi.step_held, bi.dir});
        end
        goto(p + 16);
        bi.key_step_n = 1'b1;
        goto(p + 35);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_missing_pulse: %0d pulses outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_repeat();
        test_dir();
        test_reset_mid_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Upstream input stage for the LED chaser on the 50 MHz board. It takes the two raw, active-low push-buttons (step and direction) and synchronises and debounces each one. It produces a single-cycle step pulse (with hold-to-repeat) and a toggling direction level. The chaser consumes step_pulse as its shift enable and dir as its shift direction, all in the CLOCK_50 domain.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles the synchronised input must differ from the debounced state before that state flips (20 ms at 50 MHz); must be >= 1
REPEAT_DELAY, 25000000, cycles from the initial step pulse to the first auto-repeat pulse; 0 disables auto-repeat
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses; must be >= 1
CNT_W, 26, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
key_step_n  input  1  raw step button, asynchronous, active-low (0 = pressed)
key_dir_n  input  1  raw direction button, asynchronous, active-low
step_pulse  output  1  one-cycle strobe per debounced step press and per auto-repeat
dir  output  1  direction level, toggles on each debounced dir press
step_held  output  1  debounced step level, 1 = pressed
dir_held  output  1  debounced dir level, 1 = pressed

Behaviour:
- Reset (sampled on a rising edge with reset=1):
  - both 2-FF synchronisers load 1 (released); debounced states = released.
  - all counters = 0; repeat phase = initial.
  - step_pulse=0, dir=0, step_held=0, dir_held=0.
  - reset overrides all other activity on that edge.
- Synchroniser: each key goes through two flops (s1, s2). All later logic uses s2 only.
- Debounce, per channel and independent:
  - On each edge, if s2 equals the debounced state, cnt<=0.
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1, the debounced state <= s2 and cnt<=0; else cnt<=cnt+1.
  - Latency: if the raw key is first sampled low at edge k and stays low, *_held is 1 after edge k+1+DEBOUNCE_CYCLES. Release has the same latency.
  - Any single-cycle glitch back to the debounced value restarts the count from 0.
- step_pulse:
  - Registered; high for exactly the first cycle in which step_held is 1 (call this cycle P).
  - Never asserted on release.
- Auto-repeat (REPEAT_DELAY>0):
  - rcnt<=0 and phase<=initial in cycle P.
  - While step_held=1, rcnt increments each edge. When rcnt==limit-1, step_pulse=1 for one cycle, rcnt<=0 and phase<=repeat. limit = REPEAT_DELAY in the initial phase, REPEAT_PERIOD in the repeat phase.
  - Resulting pulses occur at P, P+REPEAT_DELAY, then every REPEAT_PERIOD cycles.
  - Release (step_held falls) clears rcnt and phase immediately. No further pulses.
- dir:
  - Toggles on the edge where dir_held rises, so dir changes in the same cycle dir_held first reads 1.
  - Release has no effect. Holding dir never repeats.
- Channels are fully independent. Simultaneous presses produce step_pulse and the dir toggle in the same cycle if the debounce timing aligns. No priority between channels.
- Reset mid-operation (key held, mid-debounce, or mid-repeat):
  - All state returns to reset values; the pending pulse is lost; dir returns to 0.
  - A key still held when reset deasserts is treated as a new press: full synchroniser plus DEBOUNCE_CYCLES latency, then one step_pulse.
- Counters never wrap: they are cleared on reaching the limit or on a mismatch reset.
- No combinational path from inputs to outputs.

Test Plan:
(Common parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.)
1. Reset with both keys low -> all four outputs 0 during reset. After reset deasserts, step_held and dir_held rise 6 edges later; exactly one step_pulse; dir=1.
2. key_step_n low from edge 10 for 7 cycles, then high -> step_held=1 after edge 15, step_pulse high for cycle 15 only. step_held=0 after edge 22 with no pulse.
3. Bounce: key_step_n low 3 cycles, high 1, low steady from edge 20 -> no output during the bounce. step_held and step_pulse appear after edge 25.
4. Hold step 25 cycles past P -> step_pulse at exactly P, P+8, P+11, P+14, P+17, P+20, P+23. Release -> no further pulses. Repeat with REPEAT_DELAY=0 -> single pulse at P.
5. Press dir twice (each held 10 cycles, released 10 cycles) -> dir 0→1→0, toggling in the cycle dir_held rises; step_pulse stays 0. Press both keys together -> toggle and step_pulse in the same cycle.
6. Assert reset for 1 cycle at P+9 while step is held -> outputs 0 in the next cycle, no P+11 pulse. With the key still low, step_pulse returns 6 edges after reset deasserts and dir=0.
